truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_sweep_counter.sv | 54 +++++
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants for the truth-table sweeper: state encoding and default sizing.
// The optional early-termination behaviour is selected by the STOP_ON_FAIL_EN macro in the top.
package truth_table_sweeper_pkg;

   localparam int unsigned N_IN_DEF   = 4;
   localparam int unsigned SETTLE_DEF = 1;
   localparam int unsigned SETTLE_W   = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Vector timing for the sweeper: a settle down-counter paces samples, an index
// up-counter (one bit wider than the vector) names the vector being sampled.
module sweep_counter
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned N_IN   = N_IN_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          run_i,
   output logic          sample_c,
   output logic          last_c,
   output logic [N_IN:0] idx_o
);

   localparam int unsigned IW = N_IN + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'((1 << N_IN) - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [IW-1:0]       idx_q, idx_d;

   // Sample when the settle count has expired; reload it for the next vector.
   always_comb begin
      settle_d = settle_q;
      idx_d    = idx_q;
      sample_c = run_i && (settle_q == '0);
      last_c   = sample_c && (idx_q == LAST_IDX);
      if (load_i) begin
         settle_d = SETTLE_LD;
         idx_d    = '0;
      end else if (sample_c) begin
         settle_d = SETTLE_LD;
         idx_d    = idx_q + IW'(1);
      end else if (run_i) begin
         settle_d = settle_q - SETTLE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q <= '0;
         idx_q    <= '0;
      end else begin
         settle_q <= settle_d;
         idx_q    <= idx_d;
      end
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sequencer for an N-input combinational function: captures its truth table
// and compares it to an expected mask. STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned N_IN   = N_IN_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [(1<<N_IN)-1:0]   expected,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_f,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   captured,
   output logic                   pass,
   output logic                   fail_valid,
   output logic [N_IN-1:0]        first_fail
);

   localparam int unsigned TW = 1 << N_IN;
   localparam int unsigned IW = N_IN + 1;

`ifdef STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   state_e          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [N_IN-1:0] dut_in_q, dut_in_d;
   logic [TW-1:0]   captured_q, captured_d;
   logic [TW-1:0]   exp_q, exp_d;
   logic            pass_q, pass_d;
   logic            fail_valid_q, fail_valid_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;

   logic            load_c, run_c, sample_c, last_c;
   logic [IW-1:0]   idx_c;
   logic [N_IN-1:0] vec_c;
   logic            mism_c, new_fail_c;

   assign load_c = (state_q == IDLE) && start;
   assign run_c  = (state_q == RUN);
   assign vec_c  = idx_c[N_IN-1:0];

   sweep_counter #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load_c),
      .run_i    (run_c),
      .sample_c (sample_c),
      .last_c   (last_c),
      .idx_o    (idx_c)
   );

   // Next-state, capture and compare.
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      dut_in_d     = dut_in_q;
      captured_d   = captured_q;
      exp_d        = exp_q;
      pass_d       = pass_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
      mism_c       = dut_f != exp_q[vec_c];
      new_fail_c   = mism_c && !fail_valid_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = RUN;
               busy_d       = 1'b1;
               dut_in_d     = '0;
               captured_d   = '0;
               exp_d        = expected;
               pass_d       = 1'b0;
               fail_valid_d = 1'b0;
               first_fail_d = '0;
            end
         end
         RUN: begin
            if (sample_c) begin
               captured_d[vec_c] = dut_f;
               dut_in_d          = N_IN'(idx_c + IW'(1));
               if (new_fail_c) begin
                  fail_valid_d = 1'b1;
                  first_fail_d = vec_c;
               end
               if (last_c || (STOP_ON_FAIL && new_fail_c)) begin
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  dut_in_d = '0;
                  pass_d   = !(fail_valid_q || mism_c);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dut_in_q     <= '0;
         captured_q   <= '0;
         exp_q        <= '0;
         pass_q       <= 1'b0;
         fail_valid_q <= 1'b0;
         first_fail_q <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         dut_in_q     <= dut_in_d;
         captured_q   <= captured_d;
         exp_q        <= exp_d;
         pass_q       <= pass_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign dut_in     = dut_in_q;
   assign captured   = captured_q;
   assign pass       = pass_q;
   assign fail_valid = fail_valid_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper driving f = A&B | C&~D; expected vectors and results
// are queued at start and popped as the sweep progresses.
module tb_truth_table_sweeper;

   localparam int unsigned N_IN   = 4;
   localparam int unsigned SETTLE = 1;
   localparam int unsigned TW     = 16;
   localparam int unsigned PER    = SETTLE + 1;

   typedef struct packed {
      logic [15:0] cap;
      logic        pass;
      logic        fv;
      logic [3:0]  ff;
      logic [7:0]  last_n;
   } res_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [TW-1:0]   expected = '0;
   logic [N_IN-1:0] dut_in;
   logic            dut_f;
   logic            busy, done, pass, fail_valid;
   logic [TW-1:0]   captured;
   logic [N_IN-1:0] first_fail;

   logic [3:0] vec_q[$];
   res_t       res_q[$];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   assign dut_f = (dut_in[3] & dut_in[2]) | (dut_in[1] & ~dut_in[0]);

   truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .expected   (expected),
      .dut_in     (dut_in),
      .dut_f      (dut_f),
      .busy       (busy),
      .done       (done),
      .captured   (captured),
      .pass       (pass),
      .fail_valid (fail_valid),
      .first_fail (first_fail)
   );

   function automatic logic model_f(input logic [3:0] v);
      return (v[3] & v[2]) | (v[1] & ~v[0]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference outcome of a sweep, including per-cycle dut_in values.
   task automatic push_sweep(input logic [15:0] mask);
      res_t r;
      int   last_k;
      r      = '0;
      last_k = TW - 1;
      for (int k = 0; k < TW; k++) begin
         logic v;
         v = model_f(4'(k));
         r.cap[k] = v;
         if (v !== mask[k] && !r.fv) begin
            r.fv = 1'b1;
            r.ff = 4'(k);
`ifdef STOP_ON_FAIL_EN
            last_k = k;
            break;
`endif
         end
      end
      r.pass   = !r.fv;
      r.last_n = 8'((last_k + 1) * PER);
      for (int n = 0; n < (last_k + 1) * int'(PER); n++) vec_q.push_back(4'(n / PER));
      res_q.push_back(r);
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge after DONE.
   task automatic sweep(input logic [15:0] mask, input bit poke, input int abort_n);
      res_t r;
      expected = mask;
      push_sweep(mask);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      expected = ~mask;
      chk("e0_busy", 32'(busy), 1);
      chk("e0_captured", 32'(captured), 0);
      chk("e0_pass", 32'(pass), 0);
      chk("e0_fail_valid", 32'(fail_valid), 0);
      chk("e0_first_fail", 32'(first_fail), 0);
      r = res_q.pop_front();
      for (int n = 0; n < int'(r.last_n); n++) begin
         chk("dut_in", 32'(dut_in), 32'(vec_q.pop_front()));
         chk("busy_run", 32'(busy), 1);
         chk("done_early", 32'(done), 0);
         if (n == abort_n) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_dut_in", 32'(dut_in), 0);
            chk("rst_captured", 32'(captured), 0);
            chk("rst_done", 32'(done), 0);
            vec_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk("post_rst_idle_busy", 32'(busy), 0);
               chk("post_rst_idle_dut_in", 32'(dut_in), 0);
            end
            return;
         end
         start = poke && (n >= 9) && (n < 12);
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_dut_in", 32'(dut_in), 0);
      chk("captured", 32'(captured), 32'(r.cap));
      chk("pass", 32'(pass), 32'(r.pass));
      chk("fail_valid", 32'(fail_valid), 32'(r.fv));
      chk("first_fail", 32'(first_fail), 32'(r.ff));
      @(negedge clk);
      chk("done_clear", 32'(done), 0);
      chk("pass_held", 32'(pass), 32'(r.pass));
      chk("captured_held", 32'(captured), 32'(r.cap));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_dut_in", 32'(dut_in), 0);
      chk("reset_captured", 32'(captured), 0);
      chk("reset_pass", 32'(pass), 0);
      chk("reset_fail_valid", 32'(fail_valid), 0);
      chk("reset_first_fail", 32'(first_fail), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 0);

      sweep(16'hF444, 1'b0, -1);
      @(negedge clk);
      sweep(16'hF440, 1'b0, -1);
      @(negedge clk);
      sweep(16'hF444, 1'b1, -1);
      @(negedge clk);
      sweep(16'hF444, 1'b0, 14);
      sweep(16'hF444, 1'b0, -1);
      sweep(16'hF440, 1'b0, -1);
      sweep(16'hF444, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
